// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one fixed-latency sequential 8-bit divider between NUM_REQ clients.
// Optional DIV_ZERO_CHECK_EN: divisor 0 bypasses the divider and returns q=FF, r=dividend, err=1.
module divider_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DIV_LATENCY = 17,
    parameter int unsigned CNT_W       = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [8*NUM_REQ-1:0]   req_divisor,
    input  logic [8*NUM_REQ-1:0]   req_dividend,
    output logic [NUM_REQ-1:0]     resp_valid,
    input  logic [NUM_REQ-1:0]     resp_ready,
    output logic [7:0]             resp_quotient,
    output logic [7:0]             resp_remainder,
    output logic                   resp_err,
    output logic                   div_solve,
    output logic [7:0]             div_divisor,
    output logic [7:0]             div_dividend,
    input  logic [7:0]             div_quotient,
    input  logic [7:0]             div_remainder,
    output logic                   busy
);

    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StBusy,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        divisor_q, divisor_d;
    logic [7:0]        dividend_q, dividend_d;
    logic [7:0]        quot_q, quot_d;
    logic [7:0]        rem_q, rem_d;

    logic              found;
    logic [GW-1:0]     winner;
    logic [GW:0]       idx_sum;
    logic [GW-1:0]     next_ptr;
    logic [7:0]        sel_divisor;
    logic [7:0]        sel_dividend;

    // Search starts at rr_ptr_q, which is one past the last completed grant.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        idx_sum = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx_sum = {1'b0, rr_ptr_q} + (GW+1)'(i);
            if (idx_sum >= (GW+1)'(NUM_REQ)) begin
                idx_sum = idx_sum - (GW+1)'(NUM_REQ);
            end
            if (!found && req_valid[idx_sum[GW-1:0]]) begin
                found  = 1'b1;
                winner = idx_sum[GW-1:0];
            end
        end
    end

    always_comb begin
        sel_divisor  = '0;
        sel_dividend = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (GW'(j) == winner) begin
                sel_divisor  = req_divisor[8*j +: 8];
                sel_dividend = req_dividend[8*j +: 8];
            end
        end
    end

    assign next_ptr = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);

`ifdef DIV_ZERO_CHECK_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        divisor_d  = divisor_q;
        dividend_d = dividend_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
`ifdef DIV_ZERO_CHECK_EN
        err_d      = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d    = winner;
                    divisor_d  = sel_divisor;
                    dividend_d = sel_dividend;
`ifdef DIV_ZERO_CHECK_EN
                    if (sel_divisor == 8'd0) begin
                        state_d = StResp;
                        quot_d  = 8'hFF;
                        rem_d   = sel_dividend;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StLaunch;
                        err_d   = 1'b0;
                    end
`else
                    state_d    = StLaunch;
`endif
                end
            end
            StLaunch: begin
                cnt_d   = CNT_W'(DIV_LATENCY);
                state_d = StBusy;
            end
            StBusy: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Divider outputs are final at the edge ending the cnt_q == 1 cycle.
                if (cnt_q == CNT_W'(1)) begin
                    quot_d  = div_quotient;
                    rem_d   = div_remainder;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (resp_ready[grant_q]) begin
                    state_d  = StIdle;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            divisor_q  <= divisor_d;
            dividend_q <= dividend_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    // req_ready is gated by reset so it stays low while reset is held.
    always_comb begin
        req_ready = '0;
        if (reset && state_q == StIdle && found) begin
            req_ready = NUM_REQ'(1) << winner;
        end
    end

    assign resp_valid     = (state_q == StResp) ? (NUM_REQ'(1) << grant_q) : '0;
    assign resp_quotient  = quot_q;
    assign resp_remainder = rem_q;
    assign div_solve      = (state_q == StLaunch);
    assign div_divisor    = divisor_q;
    assign div_dividend   = dividend_q;
    assign busy           = (state_q != StIdle);

`ifndef SYNTHESIS
    a_ready_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(req_ready));
    a_ready_idle: assert property (@(posedge clk) disable iff (!reset)
        (req_ready != '0) |-> (state_q == StIdle));
    a_solve_pulse: assert property (@(posedge clk) disable iff (!reset) div_solve |=> !div_solve);
    a_resp_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(resp_valid));
`endif

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with a behavioural fixed-latency divider model.
module tb_divider_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int DIV_LATENCY = 17;
    localparam int CNT_W       = 5;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [8*NUM_REQ-1:0] req_divisor = '0;
    logic [8*NUM_REQ-1:0] req_dividend = '0;
    logic [NUM_REQ-1:0]   resp_valid;
    logic [NUM_REQ-1:0]   resp_ready = '0;
    logic [7:0]           resp_quotient;
    logic [7:0]           resp_remainder;
    logic                 resp_err;
    logic                 div_solve;
    logic [7:0]           div_divisor;
    logic [7:0]           div_dividend;
    logic [7:0]           div_quotient;
    logic [7:0]           div_remainder;
    logic                 busy;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int solve_cnt = 0;

    always #5 clk = ~clk;

    divider_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DIV_LATENCY (DIV_LATENCY),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_divisor    (req_divisor),
        .req_dividend   (req_dividend),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_quotient  (resp_quotient),
        .resp_remainder (resp_remainder),
        .resp_err       (resp_err),
        .div_solve      (div_solve),
        .div_divisor    (div_divisor),
        .div_dividend   (div_dividend),
        .div_quotient   (div_quotient),
        .div_remainder  (div_remainder),
        .busy           (busy)
    );

    // Divider model: outputs junk while running, final values become visible
    // DIV_LATENCY-1 edges after the solve edge, so they are sampled at solve+DIV_LATENCY.
    int         m_cnt;
    logic [7:0] m_a, m_b;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt <= 0;
            m_a <= '0;
            m_b <= '0;
            div_quotient <= '0;
            div_remainder <= '0;
        end else if (div_solve) begin
            m_cnt <= DIV_LATENCY - 1;
            m_a <= div_dividend;
            m_b <= div_divisor;
            div_quotient <= 8'hA5;
            div_remainder <= 8'h5A;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                div_quotient  <= (m_b == 0) ? 8'hFF : m_a / m_b;
                div_remainder <= (m_b == 0) ? m_a : m_a % m_b;
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset && div_solve) solve_cnt <= solve_cnt + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction: raise request, check grant, wait for response, check it, handshake.
    task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic ee,
                         input int elat, input int esolve, input string nm);
        int e0;
        int s0;
        int lat;
        req_divisor[8*id +: 8]  = b;
        req_dividend[8*id +: 8] = a;
        req_valid[id] = 1'b1;
        #1;
        check({nm, "_ready"}, 32'(req_ready), 32'(4'b0001 << id));
        s0 = solve_cnt;
        step();
        e0 = cyc;
        req_valid[id] = 1'b0;
        lat = -1;
        for (int c = 0; c < DIV_LATENCY + 10; c++) begin
            if (resp_valid != '0) begin
                lat = cyc - e0;
                break;
            end
            step();
        end
        check({nm, "_latency"}, 32'(lat), 32'(elat));
        check({nm, "_resp_valid"}, 32'(resp_valid), 32'(4'b0001 << id));
        check({nm, "_q"}, 32'(resp_quotient), 32'(eq));
        check({nm, "_r"}, 32'(resp_remainder), 32'(er));
        check({nm, "_err"}, 32'(resp_err), 32'(ee));
        check({nm, "_busy"}, 32'(busy), 32'd1);
        check({nm, "_solves"}, 32'(solve_cnt - s0), 32'(esolve));
        resp_ready[id] = 1'b1;
        step();
        resp_ready[id] = 1'b0;
        check({nm, "_idle"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
    } vec_t;

    vec_t vecs[8];
    int   got[5];
    int   exp_order[5];
    int   n;
    logic [7:0] q_hold;

    initial begin
        vecs[0] = '{1, 8'd100, 8'd7,   8'd14,  8'd2};
        vecs[1] = '{0, 8'd255, 8'd1,   8'd255, 8'd0};
        vecs[2] = '{3, 8'd5,   8'd9,   8'd0,   8'd5};
        vecs[3] = '{2, 8'd200, 8'd200, 8'd1,   8'd0};
        vecs[4] = '{0, 8'd50,  8'd5,   8'd10,  8'd0};
        vecs[5] = '{3, 8'd0,   8'd13,  8'd0,   8'd0};
        vecs[6] = '{1, 8'd255, 8'd16,  8'd15,  8'd15};
        vecs[7] = '{2, 8'd17,  8'd3,   8'd5,   8'd2};
        exp_order = '{0, 1, 2, 3, 0};

        // Reset state, with a request pending to show req_ready is held low.
        req_valid = 4'b0010;
        req_divisor = 32'h0303_0303;
        #2;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_solve_busy_err", {29'd0, div_solve, busy, resp_err}, 32'd0);
        check("rst_results", {16'd0, resp_quotient, resp_remainder}, 32'd0);
        check("rst_operands", {16'd0, div_divisor, div_dividend}, 32'd0);
        req_valid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();

        foreach (vecs[i]) begin
            do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 1'b0,
                  DIV_LATENCY + 1, 1, $sformatf("vec%0d", i));
        end

        // Round robin from a fresh reset, all requesting, responses always accepted.
        reset = 1'b0;
        #2;
        reset = 1'b1;
        step();
        req_dividend = {8'd40, 8'd30, 8'd20, 8'd10};
        req_divisor  = {8'd2, 8'd2, 8'd2, 8'd2};
        resp_ready = 4'b1111;
        req_valid  = 4'b1111;
        #1;
        n = 0;
        for (int c = 0; c < 150 && n < 5; c++) begin
            if (req_ready != '0) begin
                check("rr_idle_only", 32'(busy), 32'd0);
                check("rr_onehot", 32'($onehot(req_ready)), 32'd1);
                for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) got[n] = k;
                n++;
            end
            step();
        end
        req_valid = '0;
        check("rr_count", 32'(n), 32'd5);
        for (int k = 0; k < 5; k++) check($sformatf("rr_grant%0d", k), 32'(got[k]), 32'(exp_order[k]));
        for (int c = 0; c < 40 && busy; c++) step();
        check("rr_drain", 32'(busy), 32'd0);
        resp_ready = '0;

        // Backpressure: requester 2 stalls its response while requester 0 waits.
        req_divisor[23:16] = 8'd4;
        req_dividend[23:16] = 8'd99;
        req_valid[2] = 1'b1;
        #1;
        check("bp_grant2", 32'(req_ready), 32'b0100);
        step();
        req_valid[2] = 1'b0;
        req_divisor[7:0] = 8'd7;
        req_dividend[7:0] = 8'd60;
        req_valid[0] = 1'b1;
        for (int c = 0; c < DIV_LATENCY + 10 && resp_valid == '0; c++) step();
        q_hold = resp_quotient;
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", 32'(resp_valid), 32'b0100);
            check("bp_q", 32'(resp_quotient), 32'd24);
            check("bp_r", 32'(resp_remainder), 32'd3);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_no_grant", 32'(req_ready), 32'd0);
            step();
        end
        check("bp_q_stable", 32'(resp_quotient), 32'(q_hold));
        resp_ready[2] = 1'b1;
        step();
        resp_ready[2] = 1'b0;
        check("bp_resume", 32'(req_ready), 32'b0001);
        step();
        req_valid[0] = 1'b0;
        for (int c = 0; c < DIV_LATENCY + 10 && resp_valid == '0; c++) step();
        check("bp_next_valid", 32'(resp_valid), 32'b0001);
        check("bp_next_q", 32'(resp_quotient), 32'd8);
        check("bp_next_r", 32'(resp_remainder), 32'd4);
        resp_ready[0] = 1'b1;
        step();
        resp_ready[0] = 1'b0;

        // Reset five cycles after the solve edge.
        req_divisor[15:8] = 8'd9;
        req_dividend[15:8] = 8'd90;
        req_valid[1] = 1'b1;
        step();
        req_valid[1] = 1'b0;
        step();
        check("mid_solved", 32'(solve_cnt > 0), 32'd1);
        repeat (5) step();
        check("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_ctrl", {28'd0, req_ready}, 32'd0);
        check("mid_rst_resp", {28'd0, resp_valid}, 32'd0);
        check("mid_rst_flags", {29'd0, div_solve, busy, resp_err}, 32'd0);
        check("mid_rst_data", {resp_quotient, resp_remainder, div_divisor, div_dividend}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
        do_op(0, 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, DIV_LATENCY + 1, 1, "post_rst");

`ifdef DIV_ZERO_CHECK_EN
        do_op(3, 8'd42, 8'd0, 8'hFF, 8'd42, 1'b1, 0, 0, "div0");
`else
        do_op(3, 8'd42, 8'd0, 8'hFF, 8'd42, 1'b0, DIV_LATENCY + 1, 1, "div0");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
Shares one sequential 8-bit divider datapath (solve-launched, fixed-latency, no done flag) between NUM_REQ requesters. Each requester gets a valid/ready request channel and a valid/ready response channel. Arbitration is round-robin. The block drives the divider's solve and operand inputs, times the operation by counting cycles, and captures quotient and remainder. It sits between the client blocks and the divider instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DIV_LATENCY, 17, cycles from the edge that samples div_solve=1 to the first edge at which div_quotient/div_remainder are final
CNT_W, 5, width of the latency counter; must hold DIV_LATENCY

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot request accept
req_divisor  in  8*NUM_REQ  divisor, slice i belongs to requester i
req_dividend  in  8*NUM_REQ  dividend, slice i belongs to requester i
resp_valid  out  NUM_REQ  one-hot result valid
resp_ready  in  NUM_REQ  per-requester result accept
resp_quotient  out  8  shared result bus
resp_remainder  out  8  shared result bus
resp_err  out  1  divide-by-zero flag (optional feature only; otherwise tied 0)
div_solve  out  1  launch pulse to the divider
div_divisor  out  8  divider operand
div_dividend  out  8  divider operand (the divider's input_remainder)
div_quotient  in  8  divider quotient
div_remainder  in  8  divider output_remainder
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, rr pointer=0, grant=0, counter=0. All outputs are 0: req_ready, resp_valid, div_solve, the operand/result registers, busy, resp_err. Reset mid-operation abandons the transaction with no response. The divider is reset by the same system reset.
- States: IDLE, LAUNCH, BUSY, RESP.
- IDLE: if any req_valid, the winner g is the first set bit searching from (last_grant+1) mod NUM_REQ. req_ready[g]=1 combinationally this cycle only. Operands are latched into div_divisor/div_dividend, g is registered, next state is LAUNCH. If no req_valid, stay in IDLE with req_ready=0.
- LAUNCH: div_solve=1 for exactly this cycle. Counter loads DIV_LATENCY. Next state is BUSY.
- BUSY: counter decrements every cycle. On the cycle counter==1, div_quotient/div_remainder are captured into the result registers and the next state is RESP. div_divisor/div_dividend hold stable throughout.
- RESP: resp_valid[g]=1 and result buses are held stable. When resp_ready[g]=1: go to IDLE and last_grant=g. Other requesters' resp_ready are ignored.
- Latency: accept edge E0; solve is sampled at E0+1; results are captured at E0+1+DIV_LATENCY; resp_valid is high from the following cycle. Minimum request-to-request spacing is DIV_LATENCY+3 cycles.
- Only one transaction is in flight. req_ready is never asserted outside IDLE. A requester may hold req_valid while its response is pending; the next grant still follows round-robin.
- A requester's req_valid deasserting before grant is legal; that requester is simply not chosen.
- Simultaneous requests: after granting g, requester g has lowest priority in the next arbitration.
- div_solve is never asserted while the divider is mid-operation.

Optional Feature:
DIV_ZERO_CHECK_EN. When defined, a granted request with divisor==0 skips LAUNCH/BUSY and goes straight to RESP the next cycle. It returns resp_quotient=8'hFF, resp_remainder=dividend, resp_err=1, with no div_solve pulse. resp_err is 0 for all other responses. When not defined, divisor 0 is sent to the divider like any other value, resp_err is tied 0, and the result is whatever the divider produces.

Test Plan:
- Single op: requester 1 sends 100/7 -> exactly one div_solve pulse; resp_valid=4'b0010 at E0+DIV_LATENCY+2; quotient=14, remainder=2.
- Round-robin: all four req_valid held high, resp_ready tied high -> grants in order 0,1,2,3,0; each accepted only in IDLE.
- Backpressure: requester 2 holds resp_ready=0 for 10 cycles -> result is stable, busy=1, no new grant; grant resumes the cycle after the handshake.
- Boundaries: 255/1 -> q=255, r=0; 5/9 -> q=0, r=5; 200/200 -> q=1, r=0.
- Reset mid-BUSY: assert reset 5 cycles after solve -> all outputs 0 immediately; a new request 0 of 50/5 then completes with q=10, r=0.
- Divide by zero with DIV_ZERO_CHECK_EN: 42/0 -> no div_solve; resp one cycle after grant with q=8'hFF, r=42, err=1. Without the macro: div_solve pulses and err=0.
